// File: rtl/shift_sequencer.sv
// Iterative 32-bit shifter: one power-of-two stage (16, 8, 4, 2, 1) per cycle, result pulsed after five stages.
// Optional logical right shift (op 10) is enabled by defining SHIFT_SEQUENCER_SRL_EN.
module shift_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_start,
  input  logic [31:0] data_operand,
  input  logic [4:0]  ctrl_shamt,
  input  logic [1:0]  ctrl_op,
  output logic        ready,
  output logic        result_valid,
  output logic [31:0] data_result,
  output logic        op_exception
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [31:0] work;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic [2:0]  step;

  logic        stage_en;
  logic        op_ok;
  logic [31:0] sll_v;
  logic [31:0] sra_v;
`ifdef SHIFT_SEQUENCER_SRL_EN
  logic [31:0] srl_v;
`endif
  logic [31:0] stage_out;

  assign ready = (state != SHIFT);

  always_comb begin
    op_ok = 1'b0;
    case (op)
      2'b00:   op_ok = 1'b1;
      2'b01:   op_ok = 1'b1;
`ifdef SHIFT_SEQUENCER_SRL_EN
      2'b10:   op_ok = 1'b1;
`endif
      default: op_ok = 1'b0;
    endcase
  end

  // Step k tests shamt bit (4-k) and applies a fixed rewiring of distance 16>>k.
  always_comb begin
    stage_en = 1'b0;
    sll_v    = work;
    sra_v    = work;
`ifdef SHIFT_SEQUENCER_SRL_EN
    srl_v    = work;
`endif
    case (step)
      3'd0: begin
        stage_en = shamt[4];
        sll_v    = {work[15:0], 16'b0};
        sra_v    = {{16{work[31]}}, work[31:16]};
`ifdef SHIFT_SEQUENCER_SRL_EN
        srl_v    = {16'b0, work[31:16]};
`endif
      end
      3'd1: begin
        stage_en = shamt[3];
        sll_v    = {work[23:0], 8'b0};
        sra_v    = {{8{work[31]}}, work[31:8]};
`ifdef SHIFT_SEQUENCER_SRL_EN
        srl_v    = {8'b0, work[31:8]};
`endif
      end
      3'd2: begin
        stage_en = shamt[2];
        sll_v    = {work[27:0], 4'b0};
        sra_v    = {{4{work[31]}}, work[31:4]};
`ifdef SHIFT_SEQUENCER_SRL_EN
        srl_v    = {4'b0, work[31:4]};
`endif
      end
      3'd3: begin
        stage_en = shamt[1];
        sll_v    = {work[29:0], 2'b0};
        sra_v    = {{2{work[31]}}, work[31:2]};
`ifdef SHIFT_SEQUENCER_SRL_EN
        srl_v    = {2'b0, work[31:2]};
`endif
      end
      3'd4: begin
        stage_en = shamt[0];
        sll_v    = {work[30:0], 1'b0};
        sra_v    = {work[31], work[31:1]};
`ifdef SHIFT_SEQUENCER_SRL_EN
        srl_v    = {1'b0, work[31:1]};
`endif
      end
      default: stage_en = 1'b0;
    endcase
  end

  // Unsupported ops leave the work register untouched so the operand comes back unshifted.
  always_comb begin
    stage_out = work;
    if (stage_en) begin
      case (op)
        2'b00:   stage_out = sll_v;
        2'b01:   stage_out = sra_v;
`ifdef SHIFT_SEQUENCER_SRL_EN
        2'b10:   stage_out = srl_v;
`endif
        default: stage_out = work;
      endcase
    end
  end

  // data_result is loaded only on entry to DONE so it holds across a back-to-back request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      work         <= 32'b0;
      shamt        <= 5'b0;
      op           <= 2'b0;
      step         <= 3'b0;
      result_valid <= 1'b0;
      data_result  <= 32'b0;
      op_exception <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (ctrl_start) begin
            work  <= data_operand;
            shamt <= ctrl_shamt;
            op    <= ctrl_op;
            step  <= 3'b0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          work <= stage_out;
          step <= step + 3'd1;
          if (step == 3'd4) begin
            state        <= DONE;
            result_valid <= 1'b1;
            data_result  <= stage_out;
            op_exception <= !op_ok;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table of single requests plus multi-cycle corner sequences.
// Expectations for op 10 follow SHIFT_SEQUENCER_SRL_EN.
module tb_shift_sequencer;

  logic        clock;
  logic        reset_n;
  logic        ctrl_start;
  logic [31:0] data_operand;
  logic [4:0]  ctrl_shamt;
  logic [1:0]  ctrl_op;
  logic        ready;
  logic        result_valid;
  logic [31:0] data_result;
  logic        op_exception;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] exp_result;
    logic        exp_exc;
  } vec_t;

  vec_t vecs[10];

  shift_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ctrl_start   (ctrl_start),
    .data_operand (data_operand),
    .ctrl_shamt   (ctrl_shamt),
    .ctrl_op      (ctrl_op),
    .ready        (ready),
    .result_valid (result_valid),
    .data_result  (data_result),
    .op_exception (op_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Issues one request, then verifies valid arrives at the fifth edge after accept and lasts one cycle.
  task automatic apply_stimulus(input string name, input vec_t v);
    int edges;
    @(negedge clock);
    ctrl_start   = 1'b1;
    data_operand = v.operand;
    ctrl_shamt   = v.shamt;
    ctrl_op      = v.op;
    @(posedge clock);
    #1;
    ctrl_start   = 1'b0;
    data_operand = 32'hxxxx_xxxx;
    check_output({name, " ready_busy"}, {31'b0, ready}, 32'd0);
    edges = 0;
    while (!result_valid && edges < 20) begin
      @(posedge clock);
      #1;
      edges++;
    end
    check_output({name, " latency"}, edges, 32'd5);
    check_output({name, " result"}, data_result, v.exp_result);
    check_output({name, " exception"}, {31'b0, op_exception}, {31'b0, v.exp_exc});
    @(posedge clock);
    #1;
    check_output({name, " pulse_end"}, {31'b0, result_valid}, 32'd0);
    check_output({name, " result_hold"}, data_result, v.exp_result);
  endtask

  initial begin
    int pulses;

    vecs[0] = '{32'h0000_00FF,  5'd8, 2'b00, 32'h0000_FF00, 1'b0};
    vecs[1] = '{32'h8000_0000, 5'd31, 2'b01, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{32'h7000_0000,  5'd4, 2'b01, 32'h0700_0000, 1'b0};
`ifdef SHIFT_SEQUENCER_SRL_EN
    vecs[3] = '{32'h8000_0000, 5'd31, 2'b10, 32'h0000_0001, 1'b0};
`else
    vecs[3] = '{32'h8000_0000, 5'd31, 2'b10, 32'h8000_0000, 1'b1};
`endif
    vecs[4] = '{32'h1234_5678,  5'd0, 2'b00, 32'h1234_5678, 1'b0};
    vecs[5] = '{32'hDEAD_BEEF,  5'd5, 2'b11, 32'hDEAD_BEEF, 1'b1};
    vecs[6] = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b0};
    vecs[7] = '{32'hF0F0_F0F0, 5'd21, 2'b01, 32'hFFFF_FF87, 1'b0};
    vecs[8] = '{32'hA5A5_A5A5, 5'd13, 2'b00, 32'hB4B4_A000, 1'b0};
    vecs[9] = '{32'h7FFF_FFFF, 5'd31, 2'b01, 32'h0000_0000, 1'b0};

    reset_n      = 1'b0;
    ctrl_start   = 1'b0;
    data_operand = 32'h0;
    ctrl_shamt   = 5'd0;
    ctrl_op      = 2'b00;
    #23;
    check_output("reset ready", {31'b0, ready}, 32'd1);
    check_output("reset valid", {31'b0, result_valid}, 32'd0);
    check_output("reset result", data_result, 32'd0);
    check_output("reset exception", {31'b0, op_exception}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      apply_stimulus($sformatf("vec%0d", i), vecs[i]);

    // Start pulse during SHIFT must be ignored: one valid pulse in the whole window.
    @(negedge clock);
    ctrl_start   = 1'b1;
    data_operand = 32'h0000_000F;
    ctrl_shamt   = 5'd4;
    ctrl_op      = 2'b00;
    @(posedge clock);
    #1;
    ctrl_start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 2) begin
        ctrl_start   = 1'b1;
        data_operand = 32'hFFFF_FFFF;
      end else begin
        ctrl_start = 1'b0;
      end
      @(posedge clock);
      #1;
      if (result_valid) pulses++;
      if (c == 5) check_output("ignored_start result", data_result, 32'h0000_00F0);
    end
    check_output("ignored_start pulses", pulses, 32'd1);
    check_output("ignored_start idle_ready", {31'b0, ready}, 32'd1);

    // Back-to-back: start held high through DONE, second result exactly six cycles later.
    @(negedge clock);
    ctrl_start   = 1'b1;
    data_operand = 32'h0000_00FF;
    ctrl_shamt   = 5'd8;
    ctrl_op      = 2'b00;
    @(posedge clock);
    #1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clock);
      #1;
    end
    check_output("b2b first_valid", {31'b0, result_valid}, 32'd1);
    check_output("b2b first_result", data_result, 32'h0000_FF00);
    check_output("b2b done_ready", {31'b0, ready}, 32'd1);
    data_operand = 32'h7000_0000;
    ctrl_shamt   = 5'd4;
    ctrl_op      = 2'b01;
    @(posedge clock);
    #1;
    ctrl_start = 1'b0;
    check_output("b2b accepted_busy", {31'b0, ready}, 32'd0);
    for (int c = 7; c <= 10; c++) begin
      check_output($sformatf("b2b hold%0d", c), data_result, 32'h0000_FF00);
      check_output($sformatf("b2b novalid%0d", c), {31'b0, result_valid}, 32'd0);
      @(posedge clock);
      #1;
    end
    check_output("b2b hold11", data_result, 32'h0000_FF00);
    @(posedge clock);
    #1;
    check_output("b2b second_valid", {31'b0, result_valid}, 32'd1);
    check_output("b2b second_result", data_result, 32'h0700_0000);

    // Reset asserted mid-SHIFT discards the request.
    @(negedge clock);
    ctrl_start   = 1'b1;
    data_operand = 32'h0000_0001;
    ctrl_shamt   = 5'd17;
    ctrl_op      = 2'b00;
    @(posedge clock);
    #1;
    ctrl_start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("midreset ready", {31'b0, ready}, 32'd1);
    check_output("midreset result", data_result, 32'd0);
    check_output("midreset exception", {31'b0, op_exception}, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      if (result_valid) pulses++;
    end
    check_output("midreset no_valid", pulses, 32'd0);
    check_output("midreset idle_result", data_result, 32'd0);
    apply_stimulus("after_reset", '{32'h0000_0001, 5'd17, 2'b00, 32'h0002_0000, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
